// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, framing-error detection.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling (decisions land 2 cycles later).
module uart_rx #(
  parameter int unsigned SCYCLE   = 50_000_000,
  parameter int unsigned BAUDRATE = 9600
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RX,
  output logic [7:0] RXDATA,
  output logic       RXDONE,
  output logic       RXBUSY,
  output logic       RXERR
);

  localparam int unsigned BITCYC = SCYCLE / BAUDRATE;
  localparam int unsigned HALF   = BITCYC / 2;
  localparam int unsigned CW     = (BITCYC > 1) ? $clog2(BITCYC) : 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned DLY    = 2;
`else
  localparam int unsigned DLY    = 0;
`endif
  localparam logic [CW-1:0] START_CNT = CW'(HALF - 1 + DLY);
  localparam logic [CW-1:0] BIT_CNT   = CW'(BITCYC - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_WAITHI = 3'd4;

  logic          sync1_q, rxs_q, rxs_d1_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q;
  logic          samp;

`ifdef UART_RX_MAJORITY_EN
  logic rxs_d2_q;

  // Majority over the nominal sample cycle and the two cycles after it
  always_comb begin
    samp = (rxs_q & rxs_d1_q) | (rxs_q & rxs_d2_q) | (rxs_d1_q & rxs_d2_q);
  end

  always_ff @(posedge CLK) begin
    if (RESET) rxs_d2_q <= 1'b1;
    else       rxs_d2_q <= rxs_d1_q;
  end
`else
  always_comb begin
    samp = rxs_q;
  end
`endif

  // Synchronizer plus one cycle of history for falling-edge detection
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q  <= 1'b1;
      rxs_q    <= 1'b1;
      rxs_d1_q <= 1'b1;
    end else begin
      sync1_q  <= RX;
      rxs_q    <= sync1_q;
      rxs_d1_q <= rxs_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs_q && rxs_d1_q) begin
          state_d = S_START;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == START_CNT) begin
          cnt_d   = '0;
          state_d = samp ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d   = '0;
          shift_d = {samp, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d = '0;
          if (samp) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_WAITHI;
          end
        end
      end
      S_WAITHI: begin
        cnt_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign RXDATA = data_q;
  assign RXDONE = done_q;
  assign RXERR  = err_q;
  assign RXBUSY = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at SCYCLE=16, BAUDRATE=1 (16 clocks per bit, mid-bit at 8).
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       RX;
  logic [7:0] RXDATA;
  logic       RXDONE, RXBUSY, RXERR;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0;
  int done_cyc = -1, err_cyc = -1;
  bit both_seen = 1'b0;
  int t0;

  // Edge count from driving the start bit to the edge after which RXDONE/RXERR is visible:
  // 2 synchronizer edges + 1 detect edge = D at edge 3; stop decision at D+8+9*16.
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 157;
  localparam int START_DEC = 13;
`else
  localparam int LAT = 155;
  localparam int START_DEC = 11;
`endif

  uart_rx #(.SCYCLE(16), .BAUDRATE(1)) dut (
    .CLK(CLK), .RESET(RESET), .RX(RX),
    .RXDATA(RXDATA), .RXDONE(RXDONE), .RXBUSY(RXBUSY), .RXERR(RXERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RXDONE) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (RXERR) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (RXDONE && RXERR) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drives start, 8 data bits LSB first, stop; stops after ncyc clocks. Glitch inverts
  // the line for the one clock that the DUT samples at the nominal mid-bit point.
  task automatic send(input logic [7:0] b, input logic stopb, input int ncyc, input bit glitch);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 16; c++) begin
        if (k * 16 + c >= ncyc) return;
        RX = (glitch && c == 8) ? ~fr[k] : fr[k];
        tick(1);
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    RX    = 1'b1;
    tick(3);
    check("rst_data", 32'(RXDATA), 32'h00);
    check("rst_busy", 32'(RXBUSY), 32'h0);
    check("rst_done", 32'(RXDONE), 32'h0);
    check("rst_err",  32'(RXERR),  32'h0);
    RESET = 1'b0;
    tick(5);

    // Single good frame
    t0 = cyc;
    send(8'hA5, 1'b1, 160, 1'b0);
    tick(10);
    check("a5_done_cnt", 32'(done_cnt), 32'd1);
    check("a5_done_cyc", 32'(done_cyc), 32'(t0 + LAT));
    check("a5_data",     32'(RXDATA),   32'hA5);
    check("a5_err_cnt",  32'(err_cnt),  32'd0);

    // Back-to-back frames, no idle gap
    t0 = cyc;
    send(8'h00, 1'b1, 160, 1'b0);
    check("b2b0_done_cyc", 32'(done_cyc), 32'(t0 + LAT));
    check("b2b0_data",     32'(RXDATA),   32'h00);
    send(8'hFF, 1'b1, 160, 1'b0);
    tick(10);
    check("b2b1_done_cyc", 32'(done_cyc), 32'(t0 + 160 + LAT));
    check("b2b1_data",     32'(RXDATA),   32'hFF);
    check("b2b_done_cnt",  32'(done_cnt), 32'd3);

    // False start: 4 clocks low
    t0 = cyc;
    RX = 1'b0;
    tick(2);
    check("fs_busy_pre", 32'(RXBUSY), 32'h0);
    tick(1);
    check("fs_busy_d", 32'(RXBUSY), 32'h1);
    tick(1);
    RX = 1'b1;
    tick(START_DEC - 5);
    check("fs_busy_last", 32'(RXBUSY), 32'h1);
    tick(1);
    check("fs_busy_idle", 32'(RXBUSY), 32'h0);
    tick(20);
    check("fs_done_cnt", 32'(done_cnt), 32'd3);
    check("fs_err_cnt",  32'(err_cnt),  32'd0);
    check("fs_data",     32'(RXDATA),   32'hFF);

    // Framing error followed by a 50-clock break
    t0 = cyc;
    send(8'h3C, 1'b0, 160, 1'b0);
    RX = 1'b0;
    tick(50);
    check("fe_err_cnt",  32'(err_cnt),  32'd1);
    check("fe_err_cyc",  32'(err_cyc),  32'(t0 + LAT));
    check("fe_data",     32'(RXDATA),   32'hFF);
    check("fe_done_cnt", 32'(done_cnt), 32'd3);
    check("fe_busy_brk", 32'(RXBUSY),   32'h1);
    RX = 1'b1;
    tick(2);
    check("fe_busy_hold", 32'(RXBUSY), 32'h1);
    tick(1);
    check("fe_busy_idle", 32'(RXBUSY), 32'h0);
    tick(20);
    check("fe_err_once", 32'(err_cnt), 32'd1);

    // Reset at D+60 during frame 0x55
    t0 = cyc;
    send(8'h55, 1'b1, 62, 1'b0);
    RESET = 1'b1;
    tick(1);
    check("mr_data", 32'(RXDATA), 32'h00);
    check("mr_busy", 32'(RXBUSY), 32'h0);
    check("mr_done", 32'(RXDONE), 32'h0);
    check("mr_err",  32'(RXERR),  32'h0);
    RESET = 1'b0;
    RX    = 1'b1;
    tick(200);
    check("mr_no_done", 32'(done_cnt), 32'd3);
    check("mr_no_err",  32'(err_cnt),  32'd1);
    t0 = cyc;
    send(8'h81, 1'b1, 160, 1'b0);
    tick(10);
    check("mr81_data",     32'(RXDATA),   32'h81);
    check("mr81_done_cyc", 32'(done_cyc), 32'(t0 + LAT));
    check("mr81_done_cnt", 32'(done_cnt), 32'd4);

`ifdef UART_RX_MAJORITY_EN
    // One-clock inverted glitch on every nominal sample point
    t0 = cyc;
    send(8'h5A, 1'b1, 160, 1'b1);
    tick(10);
    check("mj_data",     32'(RXDATA),   32'h5A);
    check("mj_done_cyc", 32'(done_cyc), 32'(t0 + LAT));
    check("mj_done_cnt", 32'(done_cnt), 32'd5);
    check("mj_err_cnt",  32'(err_cnt),  32'd1);
`endif

    check("done_err_overlap", 32'(both_seen), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
